// File: rtl/mem_stage.sv
// Memory-access stage: latches EX results and runs one data-memory transaction per load/store.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned h/w/d accesses into error passthroughs.
module mem_stage #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        wen_in,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic        done_in,
  input  logic        error_in,
  input  logic [4:0]  rd_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] wdata_in,
  input  logic [63:0] nxtpc_in,
  input  logic [2:0]  MemOp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        valid_out,
  output logic        wen_out,
  output logic        MemRd_out,
  output logic        MemWr_out,
  output logic        done_out,
  output logic        error_out,
  output logic [4:0]  rd_out,
  output logic [63:0] data_out,
  output logic [63:0] nxtpc_out,
  output logic [2:0]  MemOp_out,
  output logic [2:0]  addr_lowbit,
  output logic [63:0] data_Rd,
  output logic        data_error,
  output logic        block
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      data_rd_d;
  logic             data_error_d;
  logic [63:0]      wdata_q;
  logic             misalign;
  logic             memop;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (valid_in && (MemRd_in || MemWr_in)) begin
      case (MemOp_in[1:0])
        2'b01:   misalign = addr_in[0];
        2'b10:   misalign = |addr_in[1:0];
        2'b11:   misalign = |addr_in[2:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign memop = valid_in & (MemRd_in | MemWr_in) & ~error_in & ~misalign;

  // Pipeline register; holds while a transaction is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      wen_out     <= 1'b0;
      MemRd_out   <= 1'b0;
      MemWr_out   <= 1'b0;
      done_out    <= 1'b0;
      error_out   <= 1'b0;
      rd_out      <= '0;
      data_out    <= '0;
      nxtpc_out   <= '0;
      MemOp_out   <= '0;
      addr_lowbit <= '0;
      wdata_q     <= '0;
    end else if (!block) begin
      valid_out   <= valid_in;
      wen_out     <= wen_in & valid_in;
      MemRd_out   <= MemRd_in;
      MemWr_out   <= MemWr_in;
      done_out    <= done_in;
      error_out   <= error_in | misalign;
      rd_out      <= rd_in;
      data_out    <= addr_in;
      nxtpc_out   <= nxtpc_in;
      MemOp_out   <= MemOp_in;
      addr_lowbit <= addr_in[2:0];
      wdata_q     <= wdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      data_Rd    <= '0;
      data_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_Rd    <= data_rd_d;
      data_error <= data_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_rd_d    = data_Rd;
    data_error_d = data_error;
    unique case (state_q)
      StIdle: begin
        if (memop) begin
          state_d      = StBusy;
          cnt_d        = '0;
          data_error_d = 1'b0;
        end
      end
      StBusy: begin
        // Completion wins over a coincident timeout.
        if (mem_ready) begin
          state_d      = StIdle;
          data_error_d = mem_err;
          if (MemRd_out) data_rd_d = mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = StIdle;
          data_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign block     = (state_q == StBusy);
  assign mem_req   = (state_q == StBusy) & ~rst;
  assign mem_we    = MemWr_out;
  assign mem_addr  = {data_out[63:3], 3'b000};
  assign mem_wdata = wdata_q << {addr_lowbit, 3'b000};

  always_comb begin
    mem_wmask = 8'h00;
    if (MemWr_out) begin
      unique case (MemOp_out[1:0])
        2'b00: mem_wmask = 8'h01 << addr_lowbit;
        2'b01: mem_wmask = 8'h03 << {addr_lowbit[2:1], 1'b0};
        2'b10: mem_wmask = 8'h0F << {addr_lowbit[2], 2'b00};
        2'b11: mem_wmask = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected WB beat/error per memory op.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, wen_in, MemRd_in, MemWr_in, done_in, error_in;
  logic [4:0]  rd_in;
  logic [63:0] addr_in, wdata_in, nxtpc_in;
  logic [2:0]  MemOp_in;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        mem_err;
  logic        valid_out, wen_out, MemRd_out, MemWr_out, done_out, error_out;
  logic [4:0]  rd_out;
  logic [63:0] data_out, nxtpc_out;
  logic [2:0]  MemOp_out, addr_lowbit;
  logic [63:0] data_Rd;
  logic        data_error, block;

  typedef struct packed {
    logic [63:0] rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   nblk;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .wen_in(wen_in), .MemRd_in(MemRd_in), .MemWr_in(MemWr_in),
    .done_in(done_in), .error_in(error_in), .rd_in(rd_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .nxtpc_in(nxtpc_in), .MemOp_in(MemOp_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .valid_out(valid_out), .wen_out(wen_out), .MemRd_out(MemRd_out), .MemWr_out(MemWr_out),
    .done_out(done_out), .error_out(error_out), .rd_out(rd_out), .data_out(data_out),
    .nxtpc_out(nxtpc_out), .MemOp_out(MemOp_out), .addr_lowbit(addr_lowbit),
    .data_Rd(data_Rd), .data_error(data_error), .block(block)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    assert (obs === exp)
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one instruction for a single latch edge, then return to a bubble.
  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] op,
                       input logic [63:0] addr, input logic [63:0] wdata);
    valid_in = 1'b1; wen_in = rd_op | ~wr_op; MemRd_in = rd_op; MemWr_in = wr_op;
    error_in = 1'b0; MemOp_in = op; addr_in = addr; wdata_in = wdata;
    @(negedge clk);
    valid_in = 1'b0; MemRd_in = 1'b0; MemWr_in = 1'b0; wen_in = 1'b0;
  endtask

  // Answer the outstanding request in BUSY cycle rc (0 = never); returns BUSY cycles seen.
  task automatic serve(input int rc, input logic [63:0] rdata, input logic err, output int c);
    c = 0;
    while (block === 1'b1 && c < 200) begin
      c++;
      mem_ready = (c == rc);
      mem_rdata = rdata;
      mem_err   = err;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_err   = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, data_Rd);
    end else begin
      passed++;
      e = exp_q.pop_front();
      chk({tag, "_rd"}, data_Rd, e.rd);
      chk({tag, "_err"}, {63'd0, data_error}, {63'd0, e.err});
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 0; wen_in = 0; MemRd_in = 0; MemWr_in = 0; done_in = 0;
    error_in = 0; rd_in = 5'd3; addr_in = 0; wdata_in = 0; nxtpc_in = 64'h100;
    MemOp_in = 0; mem_ready = 0; mem_rdata = 0; mem_err = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {63'd0, valid_out}, 64'd0);
    chk("rst_wen", {63'd0, wen_out}, 64'd0);
    chk("rst_block", {63'd0, block}, 64'd0);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_data_rd", data_Rd, 64'd0);
    chk("rst_data_err", {63'd0, data_error}, 64'd0);
    rst = 1'b0;

    // ALU op passes through with one cycle latency.
    issue(1'b0, 1'b0, 3'b011, 64'h1234, 64'h0);
    chk("alu_valid", {63'd0, valid_out}, 64'd1);
    chk("alu_wen", {63'd0, wen_out}, 64'd1);
    chk("alu_data", data_out, 64'h1234);
    chk("alu_block", {63'd0, block}, 64'd0);
    chk("alu_req", {63'd0, mem_req}, 64'd0);

    // mem_ready while idle is ignored.
    mem_ready = 1'b1; mem_rdata = 64'hFFFF;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("idle_ready_block", {63'd0, block}, 64'd0);
    chk("idle_ready_rd", data_Rd, 64'd0);

    // Load byte, ready in the 4th request cycle.
    exp_q.push_back('{rd: 64'h1122334455667788, err: 1'b0});
    issue(1'b1, 1'b0, 3'b000, 64'h8000_0005, 64'h0);
    chk("lb_req", {63'd0, mem_req}, 64'd1);
    chk("lb_addr", mem_addr, 64'h8000_0000);
    chk("lb_we", {63'd0, mem_we}, 64'd0);
    chk("lb_mask", {56'd0, mem_wmask}, 64'd0);
    chk("lb_lowbit", {61'd0, addr_lowbit}, 64'd5);
    serve(4, 64'h1122334455667788, 1'b0, nblk);
    chk("lb_block_cycles", 64'(nblk), 64'd4);
    pop_check("lb");
    @(negedge clk);
    chk("lb_hold_rd", data_Rd, 64'h1122334455667788);

    // Store half at ...06; data_Rd keeps the previous load beat.
    exp_q.push_back('{rd: 64'h1122334455667788, err: 1'b0});
    issue(1'b0, 1'b1, 3'b001, 64'h4006, 64'hABCD);
    chk("sh_we", {63'd0, mem_we}, 64'd1);
    chk("sh_mask", {56'd0, mem_wmask}, 64'hC0);
    chk("sh_wdata_hi", {48'd0, mem_wdata[63:48]}, 64'hABCD);
    chk("sh_addr", mem_addr, 64'h4000);
    serve(2, 64'h5555, 1'b0, nblk);
    chk("sh_block_cycles", 64'(nblk), 64'd2);
    pop_check("sh");

    // Store word at ...04 exercises the word mask.
    exp_q.push_back('{rd: 64'h1122334455667788, err: 1'b0});
    issue(1'b0, 1'b1, 3'b010, 64'h4004, 64'h0);
    chk("sw_mask", {56'd0, mem_wmask}, 64'hF0);
    serve(1, 64'h0, 1'b0, nblk);
    pop_check("sw");

    // Bus error on completion.
    exp_q.push_back('{rd: 64'hDEAD, err: 1'b1});
    issue(1'b1, 1'b0, 3'b011, 64'h9000, 64'h0);
    serve(1, 64'hDEAD, 1'b1, nblk);
    chk("err_block_cycles", 64'(nblk), 64'd1);
    chk("err_block", {63'd0, block}, 64'd0);
    pop_check("err");

    // Timeout: request held exactly 64 cycles.
    exp_q.push_back('{rd: 64'hDEAD, err: 1'b1});
    issue(1'b1, 1'b0, 3'b011, 64'hA000, 64'h0);
    serve(0, 64'h7777, 1'b0, nblk);
    chk("to_req_cycles", 64'(nblk), 64'd64);
    chk("to_req_after", {63'd0, mem_req}, 64'd0);
    pop_check("to");

    // Ready on the timeout edge counts as completion.
    exp_q.push_back('{rd: 64'h0BAD_F00D, err: 1'b0});
    issue(1'b1, 1'b0, 3'b011, 64'hB000, 64'h0);
    serve(64, 64'h0BAD_F00D, 1'b0, nblk);
    chk("edge_cycles", 64'(nblk), 64'd64);
    pop_check("edge");

    // error_in suppresses the transaction.
    valid_in = 1'b1; MemRd_in = 1'b1; error_in = 1'b1; addr_in = 64'hC000;
    @(negedge clk);
    valid_in = 1'b0; MemRd_in = 1'b0; error_in = 1'b0;
    chk("errin_block", {63'd0, block}, 64'd0);
    chk("errin_error_out", {63'd0, error_out}, 64'd1);

    // Reset raised in the 2nd busy cycle.
    issue(1'b1, 1'b0, 3'b011, 64'hD000, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy_req", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy_valid", {63'd0, valid_out}, 64'd0);
    chk("rst_busy_block", {63'd0, block}, 64'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 64'hE002, 64'h0);
    chk("mis_req", {63'd0, mem_req}, 64'd0);
    chk("mis_error_out", {63'd0, error_out}, 64'd1);
    chk("mis_data_err", {63'd0, data_error}, 64'd0);
`else
    exp_q.push_back('{rd: 64'h4242, err: 1'b0});
    issue(1'b1, 1'b0, 3'b010, 64'hE002, 64'h0);
    chk("mis_req", {63'd0, mem_req}, 64'd1);
    chk("mis_addr", mem_addr, 64'hE000);
    serve(1, 64'h4242, 1'b0, nblk);
    pop_check("mis");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
